sdram_req_arbiter: RTL and testbench
====================================

// Module: sdram_req_arbiter
// PURPOSE
//  Shares one ddr4_sdram_controller request port among NUM_REQ requesters (LLC slices, DMA).
//  Round-robin grant; in-order read-return routing via an outstanding-tag FIFO.
//  Periodic refresh sequencing: stop grants, drain outstanding reads, pulse refresh, hold off.
// PARAMETERS
//  NUM_REQ           4     number of requesters (>=2)
//  PADDR_BITS        19    request address width; MSB = write flag (1 = write, 0 = read)
//  MAX_OUTSTANDING   8     tag FIFO depth (max in-flight reads, power of 2)
//  REFRESH_INTERVAL  7800  cycles between refresh requests
//  REFRESH_LATENCY   350   cycles of no traffic after refresh pulse (tRFC)
// PORTS
//  clk_in            in   1                     single clock, all logic on posedge
//  rst_N_in          in   1                     synchronous, active-low reset
//  req_valid_in      in   NUM_REQ               per-requester request valid
//  req_addr_in       in   NUM_REQ*PADDR_BITS    packed addresses, requester i at [i*PADDR_BITS +: PADDR_BITS]
//  req_wdata_in      in   NUM_REQ*64            packed write data
//  req_ready_out     out  NUM_REQ               one-hot accept (high on handshake cycle only)
//  rsp_valid_out     out  NUM_REQ               one-hot read-data valid
//  rsp_data_out      out  64                    read data, shared across requesters
//  ctrl_valid_out    out  1                     request to controller
//  ctrl_addr_out     out  PADDR_BITS            granted address
//  ctrl_wdata_out    out  64                    granted write data
//  ctrl_ready_in     in   1                     controller accepts this cycle
//  ctrl_rvalid_in    in   1                     controller read data valid
//  ctrl_rdata_in     in   64                    controller read data
//  refresh_out       out  1                     one-cycle refresh command pulse
//  busy_refresh_out  out  1                     high in DRAIN or REFRESH
//  err_out           out  1                     sticky: rvalid with empty tag FIFO, or refresh overrun
// BEHAVIOUR
//  Reset: all outputs 0; rr pointer 0; tag FIFO empty; refresh counter 0; state ARB.
//  States:
//   ARB     grants allowed.
//   DRAIN   no grants; go to REFRESH when tag FIFO empty.
//   REFRESH refresh_out=1 on entry cycle; stay REFRESH_LATENCY cycles total; then ARB.
//  Grant (combinational):
//   First i with req_valid_in[i], searching from rr pointer upward with wrap.
//   Enabled only when state==ARB and !(read && tag FIFO full).
//   ctrl_valid_out / ctrl_addr_out / ctrl_wdata_out mux the winner; ctrl_valid_out=0 otherwise.
//   req_ready_out[w] = grant & ctrl_ready_in.
//  Handshake (ctrl_valid_out & ctrl_ready_in):
//   rr pointer <= winner+1 mod NUM_REQ.
//   If addr MSB==0 (read), push winner id into tag FIFO.
//   Pointer is unchanged without handshake; a requester holds valid/addr/data until ready.
//  Read return:
//   ctrl_rvalid_in pops FIFO head id.
//   Next cycle: rsp_valid_out[id]=1 and rsp_data_out=ctrl_rdata_in (1-cycle latency); otherwise rsp_valid_out=0.
//   rsp_data_out holds its last value.
//   rvalid with empty FIFO: drop it, set err_out.
//   Push and pop in the same cycle are both performed; occupancy is unchanged.
//  Refresh counter:
//   Free-running 0..REFRESH_INTERVAL-1, then wraps.
//   On wrap in ARB: go to DRAIN next cycle. A handshake in the wrap cycle still completes.
//   On wrap while in DRAIN or REFRESH: set err_out (overrun); no extra refresh is queued.
//  Reads returning during DRAIN and REFRESH are still routed.
//  Reset mid-operation: FIFO contents and pending refresh are discarded; return to reset state next cycle.
// TESTING
//  T1 reset: hold rst_N_in=0 3 cycles with all inputs active -> every output 0, no ready.
//  T2 round-robin:
//   Stimulus: all 4 requesters valid with reads, ctrl_ready_in=1.
//   Required: req_ready_out sequence 0001,0010,0100,1000,0001.
//  T3 read routing:
//   Stimulus: req2 reads 0x00100, then req0 reads; controller returns 0xAAAA then 0xBBBB.
//   Required: rsp_valid_out=0100 with 0xAAAA, then 0001 with 0xBBBB.
//  T4 tag full:
//   Stimulus: 8 reads outstanding, req1 read pending.
//   Required: ctrl_valid_out=0. A write from req3 is still granted. The first rvalid lets req1 through.
//  T5 refresh:
//   Stimulus: REFRESH_INTERVAL=20, 2 reads outstanding at wrap.
//   Required: no grants until both return; refresh_out pulses once; no grant for 350 cycles; then ARB.
//  T6 errors:
//   Stimulus: rvalid with FIFO empty.
//   Required: err_out=1 next cycle, no rsp_valid_out.
//   Stimulus: REFRESH_LATENCY > REFRESH_INTERVAL.
//   Required: err_out=1 on overrun.

Source files
------------

// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter
// Shares one SDRAM controller request port among NUM_REQ requesters.
// Round-robin grant, in-order read-return routing through a tag FIFO of
// requester ids, and periodic refresh sequencing (stop grants, drain
// outstanding reads, pulse refresh, hold off for the refresh latency).
//
// Handshake rule for both the requester side and the controller side:
// a transfer happens in the cycle where valid and ready are both high;
// valid may not depend on ready, and the source holds valid, address and
// data stable until that cycle. req_ready_out is only ever high in the
// cycle the transfer happens.
module sdram_req_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int PADDR_BITS       = 19,
  parameter int MAX_OUTSTANDING  = 8,
  parameter int REFRESH_INTERVAL = 7800,
  parameter int REFRESH_LATENCY  = 350
) (
  input  logic                          clk_in,
  input  logic                          rst_N_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*PADDR_BITS-1:0] req_addr_in,
  input  logic [NUM_REQ*64-1:0]         req_wdata_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic [NUM_REQ-1:0]            rsp_valid_out,
  output logic [63:0]                   rsp_data_out,
  output logic                          ctrl_valid_out,
  output logic [PADDR_BITS-1:0]         ctrl_addr_out,
  output logic [63:0]                   ctrl_wdata_out,
  input  logic                          ctrl_ready_in,
  input  logic                          ctrl_rvalid_in,
  input  logic [63:0]                   ctrl_rdata_in,
  output logic                          refresh_out,
  output logic                          busy_refresh_out,
  output logic                          err_out,
  output logic [1:0]                    state_dbg_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(REFRESH_INTERVAL + 1);
  localparam int LAT_W = $clog2(REFRESH_LATENCY + 1);

  localparam logic [IDX_W:0]   NUM_REQ_V = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_REQ  = IDX_W'(NUM_REQ - 1);
  localparam logic [PTR_W:0]   DEPTH_V   = (PTR_W + 1)'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] REF_LAST  = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(REFRESH_LATENCY - 1);

  localparam logic [1:0] ST_ARB     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_REFRESH = 2'd2;

  logic [1:0]         state_q,     state_d;
  logic [IDX_W-1:0]   rr_q,        rr_d;
  logic [PTR_W-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,    rd_ptr_d;
  logic [PTR_W:0]     count_q,     count_d;
  logic [CNT_W-1:0]   ref_cnt_q,   ref_cnt_d;
  logic [LAT_W-1:0]   lat_cnt_q,   lat_cnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [63:0]        rsp_data_q,  rsp_data_d;
  logic               err_q,       err_d;

  // Tag FIFO storage: requester id of every read in flight, oldest first.
  logic [IDX_W-1:0]   tag_mem_q [MAX_OUTSTANDING];

  logic               tag_full;
  logic               tag_empty;
  logic [NUM_REQ-1:0] eligible;
  logic               grant_found;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W:0]     cand;
  logic               grant_valid;
  logic               handshake;
  logic               push;
  logic               pop;
  logic               rvalid_orphan;
  logic               ref_wrap;
  logic [IDX_W-1:0]   head_id;

  assign tag_full      = (count_q == DEPTH_V);
  assign tag_empty     = (count_q == '0);
  assign head_id       = tag_mem_q[rd_ptr_q];
  assign pop           = ctrl_rvalid_in && !tag_empty;
  assign rvalid_orphan = ctrl_rvalid_in && tag_empty;
  assign ref_wrap      = (ref_cnt_q == REF_LAST);

  // A read cannot compete while every tag is in use; writes still can.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid_in[i] &&
                    !(tag_full && !req_addr_in[i*PADDR_BITS + PADDR_BITS - 1]);
    end
  end

  // Round-robin search: first eligible requester at or above rr_q, with wrap.
  always_comb begin
    grant_found = 1'b0;
    winner      = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_q} + (IDX_W + 1)'(k);
      if (cand >= NUM_REQ_V) begin
        cand = cand - NUM_REQ_V;
      end
      if (!grant_found && eligible[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        winner      = cand[IDX_W-1:0];
      end
    end
  end

  // Controller-side mux; everything is forced quiet during reset.
  always_comb begin
    grant_valid    = rst_N_in && (state_q == ST_ARB) && grant_found;
    ctrl_valid_out = grant_valid;
    ctrl_addr_out  = '0;
    ctrl_wdata_out = '0;
    req_ready_out  = '0;
    if (grant_valid) begin
      ctrl_addr_out  = req_addr_in[int'(winner)*PADDR_BITS +: PADDR_BITS];
      ctrl_wdata_out = req_wdata_in[int'(winner)*64 +: 64];
      if (ctrl_ready_in) begin
        req_ready_out[winner] = 1'b1;
      end
    end
  end

  assign handshake = grant_valid && ctrl_ready_in;
  assign push      = handshake && !ctrl_addr_out[PADDR_BITS-1];

  // Next-state for the rr pointer, tag FIFO pointers/occupancy and responses.
  always_comb begin
    rr_d = rr_q;
    if (handshake) begin
      rr_d = (winner == LAST_REQ) ? '0 : winner + 1'b1;
    end
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (pop) begin
      rsp_valid_d[head_id] = 1'b1;
      rsp_data_d           = ctrl_rdata_in;
    end
  end

  // Refresh sequencing FSM, free-running interval counter and sticky error.
  always_comb begin
    ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      ST_ARB: begin
        if (ref_wrap) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (tag_empty) begin
          state_d   = ST_REFRESH;
          lat_cnt_d = '0;
        end
      end
      ST_REFRESH: begin
        if (lat_cnt_q == LAT_LAST) begin
          state_d = ST_ARB;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
    // An interval ending while a refresh is still in progress is an overrun;
    // it is flagged but does not queue another refresh.
    err_d = err_q || rvalid_orphan || (ref_wrap && (state_q != ST_ARB));
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      state_q     <= ST_ARB;
      rr_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ref_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ref_cnt_q   <= ref_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  // Tag storage needs no reset: occupancy and pointers decide what is valid.
  always_ff @(posedge clk_in) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= winner;
    end
  end

  assign rsp_valid_out    = rsp_valid_q;
  assign rsp_data_out     = rsp_data_q;
  assign err_out          = err_q;
  assign refresh_out      = (state_q == ST_REFRESH) && (lat_cnt_q == '0);
  assign busy_refresh_out = (state_q == ST_DRAIN) || (state_q == ST_REFRESH);
  assign state_dbg_out    = state_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Bench for sdram_req_arbiter: instance "a" uses the default refresh
// interval (never reached by the arbitration tests), instance "b" uses a
// 20-cycle interval with the 350-cycle refresh latency.
module tb_sdram_req_arbiter;

  localparam int N   = 4;
  localparam int AW  = 19;
  localparam int IDW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance a signals ----------------
  logic [N-1:0]    a_req_valid = '0;
  logic [N*AW-1:0] a_req_addr  = '0;
  logic [N*64-1:0] a_req_wdata = '0;
  logic [N-1:0]    a_req_ready, a_rsp_valid;
  logic [63:0]     a_rsp_data;
  logic            a_ctrl_valid;
  logic [AW-1:0]   a_ctrl_addr;
  logic [63:0]     a_ctrl_wdata;
  logic            a_ctrl_ready = 1'b0;
  logic            a_rvalid = 1'b0;
  logic [63:0]     a_rdata = '0;
  logic            a_refresh, a_busy, a_err;
  logic [1:0]      a_dbg;

  // ---------------- instance b signals ----------------
  logic [N-1:0]    b_req_valid = '0;
  logic [N*AW-1:0] b_req_addr  = '0;
  logic [N*64-1:0] b_req_wdata = '0;
  logic [N-1:0]    b_req_ready, b_rsp_valid;
  logic [63:0]     b_rsp_data;
  logic            b_ctrl_valid;
  logic [AW-1:0]   b_ctrl_addr;
  logic [63:0]     b_ctrl_wdata;
  logic            b_ctrl_ready = 1'b0;
  logic            b_rvalid = 1'b0;
  logic [63:0]     b_rdata = '0;
  logic            b_refresh, b_busy, b_err;
  logic [1:0]      b_dbg;

  sdram_req_arbiter dut_a (
    .clk_in(clk), .rst_N_in(rst_n),
    .req_valid_in(a_req_valid), .req_addr_in(a_req_addr), .req_wdata_in(a_req_wdata),
    .req_ready_out(a_req_ready), .rsp_valid_out(a_rsp_valid), .rsp_data_out(a_rsp_data),
    .ctrl_valid_out(a_ctrl_valid), .ctrl_addr_out(a_ctrl_addr), .ctrl_wdata_out(a_ctrl_wdata),
    .ctrl_ready_in(a_ctrl_ready), .ctrl_rvalid_in(a_rvalid), .ctrl_rdata_in(a_rdata),
    .refresh_out(a_refresh), .busy_refresh_out(a_busy), .err_out(a_err),
    .state_dbg_out(a_dbg)
  );

  sdram_req_arbiter #(.REFRESH_INTERVAL(20), .REFRESH_LATENCY(350)) dut_b (
    .clk_in(clk), .rst_N_in(rst_n),
    .req_valid_in(b_req_valid), .req_addr_in(b_req_addr), .req_wdata_in(b_req_wdata),
    .req_ready_out(b_req_ready), .rsp_valid_out(b_rsp_valid), .rsp_data_out(b_rsp_data),
    .ctrl_valid_out(b_ctrl_valid), .ctrl_addr_out(b_ctrl_addr), .ctrl_wdata_out(b_ctrl_wdata),
    .ctrl_ready_in(b_ctrl_ready), .ctrl_rvalid_in(b_rvalid), .ctrl_rdata_in(b_rdata),
    .refresh_out(b_refresh), .busy_refresh_out(b_busy), .err_out(b_err),
    .state_dbg_out(b_dbg)
  );

  // ---------------- scoreboard ----------------
  // Requester ids of reads accepted by instance a, in return order.
  logic [IDW-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic a_set(input int i, input logic v, input logic [AW-1:0] addr,
                       input logic [63:0] wd);
    a_req_valid[i]          = v;
    a_req_addr[i*AW +: AW]  = addr;
    a_req_wdata[i*64 +: 64] = wd;
  endtask

  task automatic b_set(input int i, input logic v, input logic [AW-1:0] addr);
    b_req_valid[i]          = v;
    b_req_addr[i*AW +: AW]  = addr;
    b_req_wdata[i*64 +: 64] = 64'h0;
  endtask

  task automatic all_idle();
    a_req_valid = '0; a_ctrl_ready = 1'b0; a_rvalid = 1'b0;
    b_req_valid = '0; b_ctrl_ready = 1'b0; b_rvalid = 1'b0;
  endtask

  // Leaves the bench at a falling edge with reset just released (cycle 0).
  task automatic do_reset();
    all_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    a_req_valid = '1; a_ctrl_ready = 1'b1; a_rvalid = 1'b1;
    a_rdata = {$urandom, $urandom};
    for (int i = 0; i < N; i++) a_set(i, 1'b1, AW'($urandom), {$urandom, $urandom});
    rst_n = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({a_req_ready, a_rsp_valid, a_rsp_data, a_ctrl_valid, a_ctrl_addr, a_ctrl_wdata,
           a_refresh, a_busy, a_err} !== '0) begin
        errors++;
        $display("FAIL reset_outputs c=%0d ready=%b rsp_v=%b rsp_d=%h cv=%b ca=%h cw=%h ref=%b busy=%b err=%b want all 0",
                 c, a_req_ready, a_rsp_valid, a_rsp_data, a_ctrl_valid, a_ctrl_addr, a_ctrl_wdata,
                 a_refresh, a_busy, a_err);
      end
      @(negedge clk);
    end
    all_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy [5];
    logic [AW-1:0] addrs [N];
    int ids [5];
    exp_rdy[0] = 4'b0001; exp_rdy[1] = 4'b0010; exp_rdy[2] = 4'b0100;
    exp_rdy[3] = 4'b1000; exp_rdy[4] = 4'b0001;
    ids[0] = 0; ids[1] = 1; ids[2] = 2; ids[3] = 3; ids[4] = 0;
    for (int i = 0; i < N; i++) begin
      addrs[i] = {1'b0, 18'($urandom)};
      a_set(i, 1'b1, addrs[i], 64'h0);
    end
    a_ctrl_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (a_req_ready !== exp_rdy[c] || a_ctrl_addr !== addrs[ids[c]]) begin
        errors++;
        $display("FAIL rr_grant c=%0d ready=%b addr=%h want ready=%b addr=%h",
                 c, a_req_ready, a_ctrl_addr, exp_rdy[c], addrs[ids[c]]);
      end
      @(negedge clk);
    end
    a_req_valid = '0; a_ctrl_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      a_rvalid = 1'b1; a_rdata = 64'h1000 + 64'(k);
      @(negedge clk); #1;
      checks++;
      if (a_rsp_valid !== (4'b1 << ids[k]) || a_rsp_data !== 64'h1000 + 64'(k)) begin
        errors++;
        $display("FAIL rr_return k=%0d rsp_v=%b data=%h want rsp_v=%b data=%h",
                 k, a_rsp_valid, a_rsp_data, 4'b1 << ids[k], 64'h1000 + 64'(k));
      end
    end
    a_rvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_routing();
    // rr pointer now sits at requester 1.
    a_ctrl_ready = 1'b1;
    a_set(2, 1'b1, 19'h00100, 64'h0);
    #1; checks++;
    if (a_req_ready !== 4'b0100 || a_ctrl_addr !== 19'h00100) begin
      errors++;
      $display("FAIL route_grant2 ready=%b addr=%h want 0100 00100", a_req_ready, a_ctrl_addr);
    end
    @(negedge clk);
    a_set(2, 1'b0, 19'h0, 64'h0);
    a_set(0, 1'b1, 19'h00200, 64'h0);
    #1; checks++;
    if (a_req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL route_grant0 ready=%b want 0001", a_req_ready);
    end
    @(negedge clk);
    a_set(0, 1'b0, 19'h0, 64'h0);
    a_rvalid = 1'b1; a_rdata = 64'hAAAA;
    @(negedge clk);
    a_rdata = 64'hBBBB;
    #1; checks++;
    if (a_rsp_valid !== 4'b0100 || a_rsp_data !== 64'hAAAA) begin
      errors++;
      $display("FAIL route_rsp_a rsp_v=%b data=%h want 0100 AAAA", a_rsp_valid, a_rsp_data);
    end
    @(negedge clk);
    a_rvalid = 1'b0;
    #1; checks++;
    if (a_rsp_valid !== 4'b0001 || a_rsp_data !== 64'hBBBB) begin
      errors++;
      $display("FAIL route_rsp_b rsp_v=%b data=%h want 0001 BBBB", a_rsp_valid, a_rsp_data);
    end
    @(negedge clk); #1; checks++;
    if (a_rsp_valid !== 4'b0000 || a_rsp_data !== 64'hBBBB) begin
      errors++;
      $display("FAIL route_hold rsp_v=%b data=%h want 0000 BBBB", a_rsp_valid, a_rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_tag_full();
    do_reset();
    a_ctrl_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      a_set(0, 1'b1, {1'b0, 18'(c)}, 64'h0);
      #1; checks++;
      if (a_req_ready !== 4'b0001) begin
        errors++;
        $display("FAIL full_fill c=%0d ready=%b want 0001", c, a_req_ready);
      end
      @(negedge clk);
    end
    a_set(0, 1'b0, 19'h0, 64'h0);
    a_set(1, 1'b1, 19'h00011, 64'h0);
    #1; checks++;
    if (a_ctrl_valid !== 1'b0 || a_req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL full_block cv=%b ready=%b want 0 0000", a_ctrl_valid, a_req_ready);
    end
    @(negedge clk);
    a_set(3, 1'b1, 19'h40033, 64'hDEAD_BEEF_0000_0003);
    #1; checks++;
    if (a_ctrl_valid !== 1'b1 || a_req_ready !== 4'b1000 || a_ctrl_addr !== 19'h40033 ||
        a_ctrl_wdata !== 64'hDEAD_BEEF_0000_0003) begin
      errors++;
      $display("FAIL full_write cv=%b ready=%b addr=%h wd=%h want 1 1000 40033 deadbeef00000003",
               a_ctrl_valid, a_req_ready, a_ctrl_addr, a_ctrl_wdata);
    end
    @(negedge clk);
    a_set(3, 1'b0, 19'h0, 64'h0);
    a_rvalid = 1'b1; a_rdata = 64'hC0;
    #1; checks++;
    if (a_ctrl_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_cycle cv=%b want 0", a_ctrl_valid);
    end
    @(negedge clk);
    a_rvalid = 1'b0;
    #1; checks++;
    if (a_req_ready !== 4'b0010 || a_rsp_valid !== 4'b0001 || a_rsp_data !== 64'hC0) begin
      errors++;
      $display("FAIL full_release ready=%b rsp_v=%b data=%h want 0010 0001 c0",
               a_req_ready, a_rsp_valid, a_rsp_data);
    end
    @(negedge clk);
    a_set(1, 1'b0, 19'h0, 64'h0);
    for (int k = 0; k < 8; k++) begin
      a_rvalid = 1'b1; a_rdata = 64'hD0 + 64'(k);
      @(negedge clk); #1; checks++;
      if (a_rsp_valid !== ((k < 7) ? 4'b0001 : 4'b0010) || a_rsp_data !== 64'hD0 + 64'(k)) begin
        errors++;
        $display("FAIL full_drain k=%0d rsp_v=%b data=%h want %b %h",
                 k, a_rsp_valid, a_rsp_data, (k < 7) ? 4'b0001 : 4'b0010, 64'hD0 + 64'(k));
      end
    end
    a_rvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_err_empty();
    #1; checks++;
    if (a_err !== 1'b0) begin
      errors++;
      $display("FAIL err_before err=%b want 0", a_err);
    end
    @(negedge clk);
    a_rvalid = 1'b1; a_rdata = 64'hEE;
    @(negedge clk);
    a_rvalid = 1'b0;
    #1; checks++;
    if (a_err !== 1'b1 || a_rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL err_orphan err=%b rsp_v=%b want 1 0000", a_err, a_rsp_valid);
    end
    repeat (3) @(negedge clk);
    #1; checks++;
    if (a_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky err=%b want 1", a_err);
    end
    do_reset();
    #1; checks++;
    if (a_err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared err=%b want 0", a_err);
    end
  endtask

  task automatic test_random();
    logic            pend [N];
    logic [AW-1:0]   p_addr [N];
    logic [63:0]     p_wdata [N];
    int              rr;
    int              win;
    logic            full;
    logic [N-1:0]    exp_rv;
    logic [N-1:0]    exp_rdy;
    logic [63:0]     exp_rd;
    do_reset();
    exp_q.delete();
    rr = 0; exp_rv = '0; exp_rd = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]    = 1'b1;
          p_addr[i]  = {($urandom_range(0, 9) < 3), 18'($urandom)};
          p_wdata[i] = {$urandom, $urandom};
        end
        a_set(i, pend[i], p_addr[i], p_wdata[i]);
      end
      a_ctrl_ready = ($urandom_range(0, 3) != 0);
      a_rvalid     = (exp_q.size() > 0) && ($urandom_range(0, 3) == 0);
      a_rdata      = {$urandom, $urandom};
      // Reference: first pending requester from rr upward; reads skipped when 8 are in flight.
      full = (exp_q.size() >= 8);
      win  = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (rr + k) % N;
        if (win < 0 && pend[i] && !(full && !p_addr[i][AW-1])) win = i;
      end
      exp_rdy = (win >= 0 && a_ctrl_ready) ? (4'b1 << win) : 4'b0;
      #1; checks++;
      if (a_ctrl_valid !== (win >= 0) || a_req_ready !== exp_rdy ||
          (win >= 0 && (a_ctrl_addr !== p_addr[win] || a_ctrl_wdata !== p_wdata[win]))) begin
        errors++;
        $display("FAIL rand_grant cyc=%0d cv=%b ready=%b addr=%h want cv=%b ready=%b winner=%0d",
                 cyc, a_ctrl_valid, a_req_ready, a_ctrl_addr, (win >= 0), exp_rdy, win);
      end
      checks++;
      if (a_rsp_valid !== exp_rv || a_rsp_data !== exp_rd || a_err !== 1'b0 || a_busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_rsp cyc=%0d rsp_v=%b data=%h err=%b busy=%b want %b %h 0 0",
                 cyc, a_rsp_valid, a_rsp_data, a_err, a_busy, exp_rv, exp_rd);
      end
      if (a_rvalid) begin
        exp_rv = 4'b1 << exp_q.pop_front();
        exp_rd = a_rdata;
      end else begin
        exp_rv = '0;
      end
      if (win >= 0 && a_ctrl_ready) begin
        rr = (win + 1) % N;
        if (!p_addr[win][AW-1]) exp_q.push_back(IDW'(win));
        pend[win] = 1'b0;
      end
      @(negedge clk);
    end
    all_idle();
  endtask

  task automatic test_refresh();
    int  pulses;
    logic found;
    do_reset();
    // Cycle 0 is the current cycle; the 20-cycle interval wraps in cycle 19.
    for (int c = 0; c < 18; c++) begin
      #1; checks++;
      if (b_busy !== 1'b0 || b_refresh !== 1'b0) begin
        errors++;
        $display("FAIL ref_idle c=%0d busy=%b refresh=%b want 0 0", c, b_busy, b_refresh);
      end
      @(negedge clk);
    end
    b_ctrl_ready = 1'b1;
    b_set(0, 1'b1, 19'h00010);
    #1; checks++;
    if (b_req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL ref_read0 ready=%b want 0001", b_req_ready);
    end
    @(negedge clk);
    b_set(0, 1'b0, 19'h0);
    b_set(1, 1'b1, 19'h00020);
    #1; checks++;
    if (b_req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL ref_read_wrap ready=%b want 0010", b_req_ready);
    end
    @(negedge clk);
    b_set(1, 1'b0, 19'h0);
    b_set(3, 1'b1, 19'h00333);
    for (int c = 0; c < 6; c++) begin
      #1; checks++;
      if (b_ctrl_valid !== 1'b0 || b_busy !== 1'b1 || b_refresh !== 1'b0) begin
        errors++;
        $display("FAIL ref_drain c=%0d cv=%b busy=%b refresh=%b want 0 1 0",
                 c, b_ctrl_valid, b_busy, b_refresh);
      end
      @(negedge clk);
    end
    b_rvalid = 1'b1; b_rdata = 64'h11;
    @(negedge clk);
    b_rdata = 64'h22;
    #1; checks++;
    if (b_rsp_valid !== 4'b0001 || b_rsp_data !== 64'h11 || b_ctrl_valid !== 1'b0) begin
      errors++;
      $display("FAIL ref_rsp0 rsp_v=%b data=%h cv=%b want 0001 11 0", b_rsp_valid, b_rsp_data, b_ctrl_valid);
    end
    @(negedge clk);
    b_rvalid = 1'b0;
    #1; checks++;
    if (b_rsp_valid !== 4'b0010 || b_rsp_data !== 64'h22 || b_err !== 1'b0) begin
      errors++;
      $display("FAIL ref_rsp1 rsp_v=%b data=%h err=%b want 0010 22 0", b_rsp_valid, b_rsp_data, b_err);
    end
    // Refresh pulse must follow shortly after the last read returns.
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      checks++;
      if (b_ctrl_valid !== 1'b0) begin
        errors++;
        $display("FAIL ref_wait_grant c=%0d cv=%b want 0", c, b_ctrl_valid);
      end
      if (b_refresh === 1'b1) found = 1'b1;
      else begin
        @(negedge clk); #1;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL ref_pulse_timeout refresh=%b want pulse within 10 cycles", b_refresh);
    end
    pulses = 1;
    for (int c = 1; c < 350; c++) begin
      @(negedge clk); #1; checks++;
      if (b_ctrl_valid !== 1'b0 || b_busy !== 1'b1) begin
        errors++;
        $display("FAIL ref_holdoff c=%0d cv=%b busy=%b want 0 1", c, b_ctrl_valid, b_busy);
      end
      if (b_refresh === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL ref_pulse_count pulses=%0d want 1", pulses);
    end
    @(negedge clk); #1; checks++;
    if (b_ctrl_valid !== 1'b1 || b_req_ready !== 4'b1000 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL ref_resume cv=%b ready=%b busy=%b want 1 1000 0", b_ctrl_valid, b_req_ready, b_busy);
    end
    checks++;
    if (b_err !== 1'b1) begin
      errors++;
      $display("FAIL ref_overrun err=%b want 1", b_err);
    end
    @(negedge clk);
    all_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_read_routing();
    test_tag_full();
    test_err_empty();
    test_random();
    test_refresh();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
